// File: rtl/weight_sort_buffer.sv
// rtl/weight_sort_buffer.sv - insertion-sort record buffer, pops largest signed 9-bit key first
module weight_sort_buffer #(
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          in_valid,
  input  logic [13:0]   in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [13:0]   out_data,
  input  logic          out_ready,
  output logic [CW-1:0] count
);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [13:0]      slot_q [DEPTH];
  logic [13:0]      slot_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [CW-1:0]    count_q, count_d;

  logic [13:0]      up_w   [DEPTH];
  logic [13:0]      down_w [DEPTH];
  logic [DEPTH-1:0] ge;
  logic [CW-1:0]    pos_push, pos_pop, pos;
  logic             push, pop;

  assign in_ready  = (count_q != FULL_C);
  assign out_valid = (count_q != '0);
  assign out_data  = slot_q[0];
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Neighbour views; the ends read zero so shifted-in slots stay cleared.
  for (genvar g = 0; g < DEPTH; g++) begin : g_nb
    if (g < DEPTH - 1) begin : g_up
      assign up_w[g] = slot_q[g+1];
    end else begin : g_up_end
      assign up_w[g] = '0;
    end
    if (g > 0) begin : g_dn
      assign down_w[g] = slot_q[g-1];
    end else begin : g_dn_end
      assign down_w[g] = '0;
    end
  end

  // Contiguous valid slots are sorted, so the >= hits form a prefix whose
  // length is the insert position; >= places a new record behind equal keys.
  always_comb begin
    ge       = '0;
    pos_push = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ge[i]    = valid_q[i] & ($signed(slot_q[i][8:0]) >= $signed(in_data[8:0]));
      pos_push = pos_push + CW'(ge[i]);
    end
    pos_pop = pos_push - CW'(ge[0]);
  end

  always_comb begin
    slot_d  = slot_q;
    count_d = count_q;
    pos     = '0;
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
      count_d = '0;
    end else if (push && pop) begin
      // Head leaves; entries ranked above the new record move up, the rest stay.
      pos = pos_pop;
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) < pos)       slot_d[i] = up_w[i];
        else if (CW'(i) == pos) slot_d[i] = in_data;
      end
    end else if (push) begin
      pos = pos_push;
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == pos)     slot_d[i] = in_data;
        else if (CW'(i) > pos) slot_d[i] = down_w[i];
      end
      count_d = count_q + 1'b1;
    end else if (pop) begin
      for (int i = 0; i < DEPTH; i++) slot_d[i] = up_w[i];
      count_d = count_q - 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) valid_d[i] = (CW'(i) < count_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_weight_sort_buffer.sv
// tb/tb_weight_sort_buffer.sv - queue-model and directed-vector bench for weight_sort_buffer
module tb_weight_sort_buffer;

  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic          clk = 0;
  logic          rst = 1;
  logic          clear = 0;
  logic          in_valid = 0;
  logic [13:0]   in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [13:0]   out_data;
  logic          out_ready = 0;
  logic [CW-1:0] count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  logic [13:0] mq [$];

  weight_sort_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] rec(input int key, input int pl);
    logic [8:0] k;
    logic [4:0] p;
    k = key[8:0];
    p = pl[4:0];
    return {p, k};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue in pop order; a new record goes before the first strictly smaller key.
  task automatic model_insert(input logic [13:0] r);
    int p;
    p = mq.size();
    for (int i = 0; i < mq.size(); i++) begin
      if ($signed(mq[i][8:0]) < $signed(r[8:0])) begin
        p = i;
        break;
      end
    end
    mq.insert(p, r);
  endtask

  task automatic step(input bit v, input logic [13:0] d, input bit r, input bit c);
    bit mpush, mpop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    clear     = c;
    mpush = v && (mq.size() != DEPTH);
    mpop  = r && (mq.size() != 0);
    @(posedge clk);
    if (c) mq.delete();
    else begin
      if (mpop) void'(mq.pop_front());
      if (mpush) model_insert(d);
    end
    #1;
    in_valid  = 0;
    out_ready = 0;
    clear     = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", {13'b0, out_valid}, {13'b0, mq.size() != 0});
      check("out_data",  out_data, (mq.size() != 0) ? mq[0] : 14'h0000);
      check("in_ready",  {13'b0, in_ready}, {13'b0, mq.size() != DEPTH});
      check("count",     {10'b0, count}, 14'(mq.size()));
    end
  end

  task automatic pop_expect(input string name, input logic [13:0] exp);
    check(name, out_data, exp);
    step(0, '0, 1, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", {10'b0, count}, 14'h0);
    check("rst_out_data", out_data, 14'h0);
    check("rst_in_ready", {13'b0, in_ready}, 14'h1);
    rst = 0;
    chk_en = 1;

    // basic ordering with payloads tracking push order
    step(1, rec(5, 0), 0, 0);
    step(1, rec(-3, 1), 0, 0);
    step(1, rec(100, 2), 0, 0);
    step(1, rec(0, 3), 0, 0);
    check("basic_count", {10'b0, count}, 14'd4);
    pop_expect("basic_pop0", 14'h0464);
    pop_expect("basic_pop1", 14'h0005);
    pop_expect("basic_pop2", 14'h0600);
    pop_expect("basic_pop3", 14'h03FD);
    check("basic_empty_valid", {13'b0, out_valid}, 14'h0);
    check("basic_empty_count", {10'b0, count}, 14'h0);

    // sign boundary
    step(1, 14'h00FF, 0, 0);
    step(1, 14'h0100, 0, 0);
    step(1, 14'h01FF, 0, 0);
    step(1, 14'h0000, 0, 0);
    pop_expect("sign_pop0", 14'h00FF);
    pop_expect("sign_pop1", 14'h0000);
    pop_expect("sign_pop2", 14'h01FF);
    pop_expect("sign_pop3", 14'h0100);

    // equal keys keep arrival order
    step(1, rec(7, 1), 0, 0);
    step(1, rec(7, 2), 0, 0);
    step(1, rec(7, 3), 0, 0);
    pop_expect("tie_pop0", 14'h0207);
    pop_expect("tie_pop1", 14'h0407);
    pop_expect("tie_pop2", 14'h0607);

    // full buffer: no push while full even with a pop pending
    for (int i = 0; i < DEPTH; i++) step(1, rec(i * 3, i), 0, 0);
    check("full_in_ready", {13'b0, in_ready}, 14'h0);
    check("full_count", {10'b0, count}, 14'd8);
    step(1, rec(50, 9), 1, 0);
    check("full_pop_count", {10'b0, count}, 14'd7);
    check("full_pop_head", out_data, rec(18, 6));
    step(1, rec(50, 9), 0, 0);
    check("full_refill_count", {10'b0, count}, 14'd8);
    check("full_refill_head", out_data, rec(50, 9));
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1, 0);

    // simultaneous push and pop
    step(1, rec(50, 1), 0, 0);
    step(1, rec(20, 2), 0, 0);
    step(1, rec(10, 3), 0, 0);
    check("pp_head_before", out_data, rec(50, 1));
    step(1, rec(30, 4), 1, 0);
    check("pp_head_after", out_data, rec(30, 4));
    check("pp_count", {10'b0, count}, 14'd3);
    pop_expect("pp_pop0", rec(30, 4));
    pop_expect("pp_pop1", rec(20, 2));
    pop_expect("pp_pop2", rec(10, 3));

    // clear wins over push and pop
    for (int i = 0; i < 5; i++) step(1, rec(-i, i), 0, 0);
    step(1, rec(77, 7), 1, 1);
    check("clr_count", {10'b0, count}, 14'h0);
    check("clr_valid", {13'b0, out_valid}, 14'h0);
    check("clr_data", out_data, 14'h0);
    check("clr_ready", {13'b0, in_ready}, 14'h1);

    // async reset mid-burst
    step(1, rec(11, 1), 0, 0);
    step(1, rec(-22, 2), 1, 0);
    step(1, rec(33, 3), 0, 0);
    in_valid = 1;
    in_data  = rec(44, 4);
    #2;
    rst = 1;
    in_valid = 0;
    mq.delete();
    #1;
    check("arst_count", {10'b0, count}, 14'h0);
    check("arst_valid", {13'b0, out_valid}, 14'h0);
    check("arst_data", out_data, 14'h0);
    check("arst_ready", {13'b0, in_ready}, 14'h1);
    @(posedge clk);
    #1;
    rst = 0;
    step(1, rec(-1, 5), 0, 0);
    check("post_rst_head", out_data, rec(-1, 5));
    step(0, '0, 1, 0);
    step(0, '0, 0, 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
